// File: rtl/interp_line_feeder.sv
// Streams a frame from memory as edge-replicated lines for a line interpolator.
// Optional READY_STALL_EN: when defined, ready low freezes the whole feeder.
module interp_line_feeder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned HEIGHT = 16,
  parameter int unsigned LEAD   = 7,
  parameter int unsigned TAIL   = 6
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       dir,
  input  logic       ready,
  output logic [7:0] rd_addr,
  output logic       rd_en,
  input  logic [7:0] rd_data,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       cap_valid,
  output logic [7:0] cap_addr,
  output logic       busy,
  output logic       done
);
  localparam int unsigned AW = 8;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] W_C    = CW'(WIDTH);
  localparam logic [CW-1:0] H_C    = CW'(HEIGHT);
  localparam logic [CW-1:0] LEAD_C = CW'(LEAD);
  localparam logic [CW-1:0] TAIL_C = CW'(TAIL);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

  // Slot tag travelling alongside the memory read
  typedef struct packed {
    logic          valid;
    logic          cap;
    logic          last;
    logic [AW-1:0] cap_addr;
  } tag_t;

  state_t        state, state_nxt;
  logic          en;
  logic          dir_q;
  logic [CW-1:0] slot, line;
  logic [CW-1:0] n_pix, n_line, pix, cidx, addr_full, cap_full;
  logic          last_slot, last_line, is_cap;
  tag_t          tag1, tag2;
  logic          dv_q, cv_q, last_q;

`ifdef READY_STALL_EN
  assign en = ready;
`else
  logic unused_ready;
  assign unused_ready = ready;
  assign en = 1'b1;
`endif

  assign rd_en      = busy & en;
  assign data_valid = dv_q & en;
  assign cap_valid  = cv_q & en;

  // Slot -> pixel -> memory address, with edge replication at both ends
  always_comb begin
    n_pix     = dir_q ? H_C : W_C;
    n_line    = dir_q ? W_C : H_C;
    last_slot = (slot == LEAD_C + n_pix + TAIL_C - ONE_C);
    last_line = (line == n_line - ONE_C);
    if (slot < LEAD_C)              pix = '0;
    else if (slot < LEAD_C + n_pix) pix = slot - LEAD_C;
    else                            pix = n_pix - ONE_C;
    is_cap    = (slot >= LEAD_C + TAIL_C);
    cidx      = slot - (LEAD_C + TAIL_C);
    addr_full = dir_q ? (pix * W_C + line) : (line * W_C + pix);
    cap_full  = dir_q ? (cidx * W_C + line) : (line * W_C + cidx);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FEED;
      FEED:    if (en && last_slot && last_line) state_nxt = FLUSH;
      FLUSH:   if (en && last_q) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == FEED) || (state_nxt == FLUSH);
      done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot  <= '0;
      line  <= '0;
      dir_q <= 1'b0;
    end else if (state == IDLE) begin
      slot <= '0;
      line <= '0;
      if (start) dir_q <= dir;
    end else if ((state == FEED) && en) begin
      if (last_slot) begin
        slot <= '0;
        line <= line + ONE_C;
      end else begin
        slot <= slot + ONE_C;
      end
    end
  end

  // Issue register, memory-latency stage, output register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr  <= '0;
      tag1     <= '0;
      tag2     <= '0;
      data_out <= '0;
      cap_addr <= '0;
      dv_q     <= 1'b0;
      cv_q     <= 1'b0;
      last_q   <= 1'b0;
    end else if (en) begin
      if (state == FEED) rd_addr <= AW'(addr_full);
      tag1.valid    <= (state == FEED);
      tag1.cap      <= (state == FEED) && is_cap;
      tag1.last     <= (state == FEED) && last_slot && last_line;
      tag1.cap_addr <= AW'(cap_full);
      tag2          <= tag1;
      dv_q          <= tag2.valid;
      cv_q          <= tag2.cap;
      last_q        <= tag2.last;
      if (tag2.valid) begin
        data_out <= rd_data;
        cap_addr <= tag2.cap_addr;
      end
    end
  end
endmodule
